// File: rtl/ioblock_array.sv
// ioblock_array: multi-channel configurable IO block with a scan-loaded
// shadow config, load-strobe commit and per-channel data registers.
module ioblock_array #(
    parameter int NCH   = 4,
    parameter int CBITS = 4
) (
    input  logic           IOCLK,
    input  logic           RSTN,
    inout  wire  [NCH-1:0] PIN,
    input  logic [NCH-1:0] TS,
    input  logic [NCH-1:0] OUT,
    output logic [NCH-1:0] IN,
    input  logic           CFG_SE,
    input  logic           CFG_SI,
    input  logic           CFG_LD,
    output logic           CFG_SO
);

    localparam int W = NCH * CBITS;

    logic [W-1:0]   sh;
    logic [W-1:0]   act;
    logic [NCH-1:0] d_q;
    logic [NCH-1:0] out_q;
    logic [NCH-1:0] ts_q;

    // Commit samples the pre-edge shadow, so shift and load may coincide.
    always_ff @(posedge IOCLK or negedge RSTN) begin
        if (!RSTN) begin
            sh    <= '0;
            act   <= '0;
            d_q   <= '0;
            out_q <= '0;
            ts_q  <= '0;
        end else begin
            if (CFG_SE) begin
                sh <= {sh[W-2:0], CFG_SI};
            end
            if (CFG_LD) begin
                act <= sh;
            end
            d_q   <= PIN;
            out_q <= OUT;
            ts_q  <= TS;
        end
    end

    assign CFG_SO = sh[W-1];

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic       direg;
        logic       doreg;
        logic [1:0] tsmode;
        logic       oe_c;
        logic       dv_c;

        assign direg  = act[CBITS*c];
        assign doreg  = act[CBITS*c+1];
        assign tsmode = act[CBITS*c+3 -: 2];

        always_comb begin
            oe_c = 1'b0;
            unique case (tsmode)
                2'b00: oe_c = 1'b0;
                2'b01: oe_c = TS[c];
                2'b10: oe_c = 1'b1;
                2'b11: oe_c = ts_q[c];
                default: oe_c = 1'b0;
            endcase
        end

        assign dv_c   = doreg ? out_q[c] : OUT[c];
        assign PIN[c] = oe_c ? dv_c : 1'bz;
        assign IN[c]  = direg ? d_q[c] : PIN[c];
    end

endmodule

// File: tb/tb_ioblock_array.sv
// tb_ioblock_array: directed vectors for ioblock_array with
// hand-computed expectations; external pin drivers model the board.
module tb_ioblock_array;

    logic       IOCLK = 1'b0;
    logic       RSTN  = 1'b0;
    wire  [3:0] PIN;
    logic [3:0] TS    = 4'h0;
    logic [3:0] OUT   = 4'h0;
    logic [3:0] IN;
    logic       CFG_SE = 1'b0;
    logic       CFG_SI = 1'b0;
    logic       CFG_LD = 1'b0;
    logic       CFG_SO;

    logic [3:0] ext_en  = 4'h0;
    logic [3:0] ext_val = 4'h0;

    int nvec = 0;
    int nerr = 0;

    ioblock_array #(.NCH(4), .CBITS(4)) dut (
        .IOCLK (IOCLK),
        .RSTN  (RSTN),
        .PIN   (PIN),
        .TS    (TS),
        .OUT   (OUT),
        .IN    (IN),
        .CFG_SE(CFG_SE),
        .CFG_SI(CFG_SI),
        .CFG_LD(CFG_LD),
        .CFG_SO(CFG_SO)
    );

    always #5 IOCLK = ~IOCLK;

    for (genvar i = 0; i < 4; i++) begin : g_ext
        assign PIN[i] = ext_en[i] ? ext_val[i] : 1'bz;
    end

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge IOCLK);
        #1;
    endtask

    task automatic shift(input logic [15:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            CFG_SE = 1'b1;
            CFG_SI = w[i];
            step();
        end
        CFG_SE = 1'b0;
    endtask

    task automatic commit();
        CFG_LD = 1'b1;
        step();
        CFG_LD = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [23:0] s;
        int          idx;

        // reset state with external drive
        ext_en  = 4'hF;
        ext_val = 4'hA;
        OUT     = 4'h5;
        TS      = 4'hF;
        #2;
        check("rst_so", CFG_SO, 0);
        check("rst_in", IN, 4'hA);
        check("rst_pin", PIN, 4'hA);
        step();
        RSTN = 1'b1;

        // scan ch0 = 0100, no pin change before commit
        ext_val = 4'h0;
        OUT     = 4'hF;
        TS      = 4'hF;
        shift(16'h0004, 16);
        check("t2_preld_pin", PIN, 4'h0);
        commit();
        ext_en = 4'hE;
        #1;
        check("t2_drv1", PIN[0], 1);
        check("t2_in", IN[0], 1);
        OUT[0] = 1'b0;
        #1;
        check("t2_drv0", PIN[0], 0);
        TS[0]   = 1'b0;
        OUT[0]  = 1'b1;
        ext_en  = 4'hF;
        ext_val = 4'h0;
        #1;
        check("t2_hiz_a", PIN[0], 0);
        OUT[0]     = 1'b0;
        ext_val[0] = 1'b1;
        #1;
        check("t2_hiz_b", PIN[0], 1);

        // ch1 = 1010: always drive, registered output
        ext_val = 4'h0;
        OUT     = 4'h0;
        TS      = 4'h0;
        shift(16'h00A0, 16);
        commit();
        ext_en = 4'hD;
        step();
        check("t3_low", PIN[1], 0);
        OUT[1] = 1'b1;
        #1;
        check("t3_notyet", PIN[1], 0);
        step();
        check("t3_rise", PIN[1], 1);
        check("t3_in", IN[1], 1);
        OUT[1] = 1'b0;
        #1;
        check("t3_hold", PIN[1], 1);
        step();
        check("t3_fall", PIN[1], 0);

        // ch2 = 1101: registered TS, registered input
        ext_en  = 4'hF;
        ext_val = 4'h0;
        OUT     = 4'h0;
        TS      = 4'h0;
        shift(16'h0D00, 16);
        commit();
        ext_val[2] = 1'b1;
        #1;
        check("t4_hiz", PIN[2], 1);
        check("t4_in_pre", IN[2], 0);
        step();
        check("t4_in_cap", IN[2], 1);
        ext_val[2] = 1'b0;
        OUT[2]     = 1'b1;
        TS[2]      = 1'b1;
        #1;
        check("t4_ts_pre", PIN[2], 0);
        step();
        ext_en[2] = 1'b0;
        #1;
        check("t4_drive", PIN[2], 1);
        check("t4_in_lag", IN[2], 0);
        step();
        check("t4_in_drv", IN[2], 1);

        // simultaneous shift and commit
        TS      = 4'h0;
        OUT     = 4'h0;
        ext_en  = 4'hF;
        ext_val = 4'h0;
        shift(16'h8000, 16);
        check("t5_so_pre", CFG_SO, 1);
        CFG_SE = 1'b1;
        CFG_SI = 1'b0;
        CFG_LD = 1'b1;
        step();
        CFG_SE = 1'b0;
        CFG_LD = 1'b0;
        OUT[3] = 1'b1;
        ext_en = 4'h7;
        #1;
        check("t5_act", PIN[3], 1);
        check("t5_so", CFG_SO, 0);

        // scan-through: first 8 bits reappear after 16 shifts
        s = {8'b1011_0010, 16'hC35A};
        for (int k = 1; k <= 24; k++) begin
            CFG_SE = 1'b1;
            CFG_SI = s[24-k];
            step();
            if (k >= 16 && k <= 23) begin
                idx = 39 - k;
                check($sformatf("t6_so%0d", k), CFG_SO, s[idx]);
            end
        end
        CFG_SE = 1'b0;
        check("t6_act_kept", PIN[3], 1);

        // async reset while all channels drive
        shift(16'h8888, 16);
        commit();
        OUT    = 4'hF;
        ext_en = 4'h0;
        #1;
        check("drv_all", PIN, 4'hF);
        #3;
        RSTN    = 1'b0;
        ext_en  = 4'hF;
        ext_val = 4'h0;
        #1;
        check("mrst_pin", PIN, 4'h0);
        check("mrst_in", IN, 4'h0);
        check("mrst_so", CFG_SO, 0);
        ext_val = 4'hA;
        #1;
        check("mrst_in2", IN, 4'hA);
        @(negedge IOCLK);
        RSTN = 1'b1;
        step();
        ext_val = 4'h5;
        OUT     = 4'hA;
        #1;
        check("post_rst_pin", PIN, 4'h5);
        check("post_rst_so", CFG_SO, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
